// File: rtl/trace_history.sv
// Decimated position trail: shifts the latched tracker position into a DEPTH-deep
// history on capture frames, freezes on misses and clears after MISS_LIMIT misses.
module trace_slot (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        push_i,
  input  logic        clr_i,
  input  logic [10:0] x_i,
  input  logic [9:0]  y_i,
  input  logic        v_i,
  output logic [10:0] x_o,
  output logic [9:0]  y_o,
  output logic        v_o
);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_o <= '0;
      y_o <= '0;
      v_o <= 1'b0;
    end else if (push_i) begin
      x_o <= x_i;
      y_o <= y_i;
      v_o <= v_i;
    end else if (clr_i) begin
      v_o <= 1'b0;
    end
  end
endmodule

module trace_history #(
  parameter int DEPTH      = 5,
  parameter int DECIM      = 1,
  parameter int MISS_LIMIT = 8,
  parameter int H_MAX      = 1279,
  parameter int V_MAX      = 719
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    nf_in,
  input  logic                    valid_in,
  input  logic [11:0]             x_in,
  input  logic [10:0]             y_in,
  output logic [DEPTH-1:0][10:0]  trail_x_out,
  output logic [DEPTH-1:0][9:0]   trail_y_out,
  output logic [DEPTH-1:0]        trail_valid_out,
  output logic                    update_out
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [7:0]  miss_q, miss_d;
  logic [10:0] pend_x_q, pend_x_d, x_cl;
  logic [9:0]  pend_y_q, pend_y_d, y_cl;
  logic        seen_q, seen_d;
  logic        update_q;
  logic        capture, push, clr;

  assign x_cl    = (x_in > 12'(H_MAX)) ? 11'(H_MAX) : x_in[10:0];
  assign y_cl    = (y_in > 11'(V_MAX)) ? 10'(V_MAX) : y_in[9:0];
  assign capture = nf_in && (fcnt_q == 4'(DECIM - 1));

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    miss_d   = miss_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    seen_d   = seen_q;
    push     = 1'b0;
    clr      = 1'b0;
    if (nf_in) fcnt_d = capture ? 4'd0 : fcnt_q + 4'd1;
    if (capture) begin
      seen_d = 1'b0;
      if (seen_q) begin
        push    = 1'b1;
        miss_d  = '0;
        state_d = ST_TRACK;
      end else begin
        unique case (state_q)
          ST_TRACK, ST_HOLD: begin
            // miss_q is zero in TRACK, so one rule serves both states
            if ({1'b0, miss_q} + 9'd1 >= 9'(MISS_LIMIT)) begin
              clr     = 1'b1;
              miss_d  = '0;
              state_d = ST_EMPTY;
            end else begin
              miss_d  = miss_q + 8'd1;
              state_d = ST_HOLD;
            end
          end
          default: ;
        endcase
      end
    end
    // a sample in the nf cycle belongs to the following frame
    if (valid_in) begin
      pend_x_d = x_cl;
      pend_y_d = y_cl;
      seen_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_EMPTY;
      fcnt_q   <= '0;
      miss_q   <= '0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      seen_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      miss_q   <= miss_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      seen_q   <= seen_d;
      update_q <= push | clr;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g == 0) begin : g_head
      trace_slot u_slot (
        .clk_in(clk_in), .rst_in(rst_in), .push_i(push), .clr_i(clr),
        .x_i(pend_x_q), .y_i(pend_y_q), .v_i(1'b1),
        .x_o(trail_x_out[g]), .y_o(trail_y_out[g]), .v_o(trail_valid_out[g])
      );
    end else begin : g_tail
      trace_slot u_slot (
        .clk_in(clk_in), .rst_in(rst_in), .push_i(push), .clr_i(clr),
        .x_i(trail_x_out[g-1]), .y_i(trail_y_out[g-1]), .v_i(trail_valid_out[g-1]),
        .x_o(trail_x_out[g]), .y_o(trail_y_out[g]), .v_o(trail_valid_out[g])
      );
    end
  end

  assign update_out = update_q;
endmodule

// File: tb/tb_trace_history.sv
// Scoreboard bench: two configurations share one random/directed stimulus stream;
// a reference model queues expected trails, a monitor pops them on update_out.
module tb_trace_history;
  logic clk = 1'b0, rst = 1'b1, nf = 1'b0, vld = 1'b0;
  logic [11:0] x = '0;
  logic [10:0] y = '0;
  logic [4:0][10:0] t0x;
  logic [4:0][9:0]  t0y;
  logic [4:0]       t0v;
  logic             upd0;
  logic [2:0][10:0] t1x;
  logic [2:0][9:0]  t1y;
  logic [2:0]       t1v;
  logic             upd1;

  always #5 clk = ~clk;

  trace_history dut0 (
    .clk_in(clk), .rst_in(rst), .nf_in(nf), .valid_in(vld), .x_in(x), .y_in(y),
    .trail_x_out(t0x), .trail_y_out(t0y), .trail_valid_out(t0v), .update_out(upd0)
  );
  trace_history #(.DEPTH(3), .DECIM(3), .MISS_LIMIT(2)) dut1 (
    .clk_in(clk), .rst_in(rst), .nf_in(nf), .valid_in(vld), .x_in(x), .y_in(y),
    .trail_x_out(t1x), .trail_y_out(t1y), .trail_valid_out(t1v), .update_out(upd1)
  );

  typedef struct packed {
    logic [7:0][10:0] x;
    logic [7:0][9:0]  y;
    logic [7:0]       v;
  } trail_t;
  typedef struct packed {
    trail_t      t;
    logic [10:0] px;
    logic [9:0]  py;
    logic        seen;
    logic [7:0]  fcnt;
    logic [8:0]  miss;
  } model_t;

  model_t m0 = '0, m1 = '0;
  trail_t q0[$], q1[$];
  trail_t e0, e1;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: the trail is empty when no slot is valid; a miss only counts
  // against a non-empty trail and wipes it once MISS_LIMIT misses are reached.
  task automatic mstep(input model_t mi, input int D, input int DEC, input int ML,
                       output model_t mo, output bit u);
    mo = mi;
    u  = 1'b0;
    if (nf) begin
      if (int'(mo.fcnt) == DEC - 1) begin
        mo.fcnt = '0;
        if (mo.seen) begin
          for (int i = D - 1; i > 0; i--) begin
            mo.t.x[i] = mo.t.x[i-1];
            mo.t.y[i] = mo.t.y[i-1];
            mo.t.v[i] = mo.t.v[i-1];
          end
          mo.t.x[0] = mo.px;
          mo.t.y[0] = mo.py;
          mo.t.v[0] = 1'b1;
          mo.miss   = '0;
          u = 1'b1;
        end else if (mo.t.v != '0) begin
          mo.miss = mo.miss + 9'd1;
          if (int'(mo.miss) == ML) begin
            mo.t.v  = '0;
            mo.miss = '0;
            u = 1'b1;
          end
        end
        mo.seen = 1'b0;
      end else begin
        mo.fcnt = mo.fcnt + 8'd1;
      end
    end
    if (vld) begin
      mo.px   = (x > 12'd1279) ? 11'd1279 : x[10:0];
      mo.py   = (y > 11'd719) ? 10'd719 : y[9:0];
      mo.seen = 1'b1;
    end
  endtask

  task automatic cyc(input bit n, input bit v, input int xx, input int yy);
    model_t nm;
    bit u;
    nf  = n;
    vld = v;
    x   = xx[11:0];
    y   = yy[10:0];
    mstep(m0, 5, 1, 8, nm, u);
    m0 = nm;
    if (u) q0.push_back(m0.t);
    mstep(m1, 3, 3, 2, nm, u);
    m1 = nm;
    if (u) q1.push_back(m1.t);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " d0 trail_x"}, int'(|t0x), 0);
    chk({tag, " d0 trail_y"}, int'(|t0y), 0);
    chk({tag, " d0 trail_valid"}, int'(t0v), 0);
    chk({tag, " d0 update_out"}, int'(upd0), 0);
    chk({tag, " d1 trail_x"}, int'(|t1x), 0);
    chk({tag, " d1 trail_valid"}, int'(t1v), 0);
    chk({tag, " d1 update_out"}, int'(upd1), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (upd0) begin
        if (q0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL d0 update_out: got 1 expected 0 (no capture event)");
        end else begin
          e0 = q0.pop_front();
          for (int i = 0; i < 5; i++) begin
            chk($sformatf("d0 slot%0d x", i), int'(t0x[i]), int'(e0.x[i]));
            chk($sformatf("d0 slot%0d y", i), int'(t0y[i]), int'(e0.y[i]));
            chk($sformatf("d0 slot%0d v", i), int'(t0v[i]), int'(e0.v[i]));
          end
        end
      end
      if (upd1) begin
        if (q1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL d1 update_out: got 1 expected 0 (no capture event)");
        end else begin
          e1 = q1.pop_front();
          for (int i = 0; i < 3; i++) begin
            chk($sformatf("d1 slot%0d x", i), int'(t1x[i]), int'(e1.x[i]));
            chk($sformatf("d1 slot%0d y", i), int'(t1y[i]), int'(e1.y[i]));
            chk($sformatf("d1 slot%0d v", i), int'(t1v[i]), int'(e1.v[i]));
          end
        end
      end
    end
  end

  function automatic int rx();
    int r = $urandom_range(3);
    return (r == 0) ? 1275 + $urandom_range(8) : $urandom_range(4095);
  endfunction
  function automatic int ry();
    int r = $urandom_range(3);
    return (r == 0) ? 715 + $urandom_range(8) : $urandom_range(2047);
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    // six frames of a fixed position, then clamping
    for (int f = 0; f < 6; f++) begin
      cyc(0, 1, 100, 200);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
    end
    cyc(0, 1, 3000, 900);
    cyc(1, 0, 0, 0);
    // eight misses wipe the default trail
    for (int f = 0; f < 8; f++) begin
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
    end
    // refill, three misses, then recover
    for (int f = 0; f < 5; f++) begin
      cyc(0, 1, 10 * f + 1, 20 * f + 2);
      cyc(1, 0, 0, 0);
    end
    for (int f = 0; f < 3; f++) cyc(1, 0, 0, 0);
    cyc(0, 1, 50, 60);
    cyc(1, 0, 0, 0);
    // decimated group: sample only in its first frame, then a same-cycle sample
    while (m1.fcnt != 0) cyc(1, 0, 0, 0);
    cyc(0, 1, 321, 123);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 77, 88);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // random frames with occasional miss streaks and same-cycle samples
    for (int f = 0; f < 150; f++) begin
      bit act = ($urandom_range(2) != 0);
      int len = $urandom_range(4);
      for (int c = 0; c < len; c++) cyc(0, act && ($urandom_range(1) == 1), rx(), ry());
      cyc(1, $urandom_range(5) == 0, rx(), ry());
    end
    // fill, leave a pending sample, then async reset between edges
    for (int f = 0; f < 6; f++) begin
      cyc(0, 1, 400 + f, 300 + f);
      cyc(1, 0, 0, 0);
    end
    cyc(0, 1, 7, 7);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async reset");
    m0 = '0;
    m1 = '0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    chk_zero("reset held");
    rst = 1'b0;
    for (int f = 0; f < 3; f++) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("post-reset d0 trail_valid", int'(t0v), 0);
    chk("post-reset d1 trail_valid", int'(t1v), 0);
    chk("d0 pending expected updates", q0.size(), 0);
    chk("d1 pending expected updates", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_history.md
TRACE_HISTORY -- requirements
Module: trace_history

Interface
REQ-001 Parameter DEPTH, default 5, number of trail slots (slot 0 newest).
REQ-002 Parameter DECIM, default 1, frames per capture event (range 1-15).
REQ-003 Parameter MISS_LIMIT, default 8, consecutive missed capture events before the trail is cleared (range 1-255).
REQ-004 Parameter H_MAX, default 1279, largest legal hcount position.
REQ-005 Parameter V_MAX, default 719, largest legal vcount position.
REQ-006 clk_in  input  1  single clock for all logic.
REQ-007 rst_in  input  1  reset, asynchronous, active-high.
REQ-008 nf_in  input  1  one-cycle new-frame pulse.
REQ-009 valid_in  input  1  tracker position valid this cycle.
REQ-010 x_in  input  12  tracker x position.
REQ-011 y_in  input  11  tracker y position.
REQ-012 trail_x_out  output  DEPTH x 11  slot hcount positions.
REQ-013 trail_y_out  output  DEPTH x 10  slot vcount positions.
REQ-014 trail_valid_out  output  DEPTH  per-slot valid flags.
REQ-015 update_out  output  1  one-cycle pulse the cycle after the trail shifts or clears.

Function
REQ-016 Clamping: x_in > H_MAX -> H_MAX; y_in > V_MAX -> V_MAX; all other values are truncated to 11/10 bits unchanged.
REQ-017 Latch: each cycle with valid_in=1 and nf_in=0, the clamped x/y are stored in a pending register and frame_seen is set.
REQ-018 Same-cycle case: valid_in=1 coinciding with nf_in=1 belongs to the next frame; it is loaded into pending after the event is evaluated, with frame_seen=1.
REQ-019 Decimation: a frame counter counts nf_in pulses 0..DECIM-1; only the pulse at count DECIM-1 is a capture event, and the counter then wraps to 0.
REQ-020 Non-capture nf_in pulses leave pending and frame_seen unchanged, so they accumulate across the DECIM frames.
REQ-021 At every capture event frame_seen is cleared, unless REQ-018 applies.
REQ-022 Push: slot[i] <= slot[i-1] for i = DEPTH-1..1, with x, y and valid shifted together; slot[0] <= pending with valid=1; the oldest slot is discarded.
REQ-023 State EMPTY: all trail_valid_out bits are 0; a capture event with frame_seen=1 pushes and moves to TRACK; a capture without frame_seen does nothing.
REQ-024 State TRACK: capture with frame_seen pushes; capture without frame_seen sets miss_cnt=1, does not shift, and moves to HOLD (or clears per REQ-026 when MISS_LIMIT=1).
REQ-025 State HOLD: the trail is frozen; capture with frame_seen pushes, clears miss_cnt, and moves to TRACK; capture without frame_seen increments miss_cnt.
REQ-026 Clear: when miss_cnt reaches MISS_LIMIT, all valid bits are cleared, x/y are retained, miss_cnt is cleared, and the state moves to EMPTY.
REQ-027 Latency: outputs change on the clock edge that samples the capture nf_in; update_out is high on the following cycle only.
REQ-028 update_out pulses for push and clear only; it does not pulse for HOLD freezes or EMPTY no-ops.
REQ-029 Outputs are registered and stable between capture events.

Reset
REQ-030 rst_in=1 asynchronously forces the following and holds them while asserted:
- all trail_x_out, trail_y_out, trail_valid_out = 0
- update_out = 0
- pending = 0, frame_seen = 0, frame counter = 0, miss_cnt = 0
- state = EMPTY
REQ-031 Reset asserted mid-frame discards the pending sample; the first capture after release requires a fresh valid_in.

Verification
REQ-032 Defaults; valid_in with (100,200) each frame for 6 frames -> after 5th nf slots 0..4 are valid, slot0=(100,200)...; 6th nf drops the oldest slot; update_out pulses once per nf.
REQ-033 x_in=12'd3000, y_in=11'd900 valid then nf -> slot0=(1279,719).
REQ-034 Trail full, then no valid_in for 7 nf -> trail unchanged, no update_out; 8th nf -> all valid=0, update_out=1, state EMPTY.
REQ-035 In HOLD after 3 misses, valid (50,60) then nf -> push slot0=(50,60), miss_cnt=0, TRACK; older slots intact and shifted one.
REQ-036 DECIM=3: valid only in frame 1 of a group, nf x3 -> single push on 3rd nf using the frame-1 position; nf with valid_in same cycle -> value appears at the next capture, not the current one.
REQ-037 rst_in pulsed asynchronously (between clock edges) with a full trail -> outputs zero immediately; next nf without valid_in -> no push, update_out=0.
